nes_pad_controller: RTL and testbench
=====================================

Name: nes_pad_controller

Overview:
Sequences the NES gamepad's serial shift register by driving the latch and clock pins, deserialising the 8 button bits, and registering a clean button vector. It replaces direct wiring of button lines into the decoder. It also generates the adder/subtractor mux select and one-cycle select/start event pulses for the datapath. It sits between the pad connector pins and the arithmetic datapath.

Parameters:
HALF_CYCLES, 300, clk cycles per protocol tick (one latch/clock half-period); must be >= 1
POLL_TICKS, 2000, ticks spent in IDLE between polls; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
nes_data  input  1  pad serial data, active-low (0 = pressed)
nes_latch  output  1  pad latch pin, active-high
nes_clk  output  1  pad clock pin, active-high pulse
buttons  output  8  registered pressed state, 1 = pressed; [7]=A [6]=B [5]=Select [4]=Start [3]=Up [2]=Down [1]=Left [0]=Right
buttons_valid  output  1  one-cycle pulse when buttons updates
mux_select  output  1  0 = add, 1 = subtract
select_pulse  output  1  one-cycle pulse on Select press edge
start_pulse  output  1  one-cycle pulse on Start press edge

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset, including mid-frame: state=IDLE, divider=0, poll count=0, bit count=0, shift=0.
- Reset values of all outputs: nes_latch=0, nes_clk=0, buttons=0, buttons_valid=0, mux_select=0, select_pulse=0, start_pulse=0.
- Tick generator: free-running counter 0..HALF_CYCLES-1. tick=1 on the cycle the count equals HALF_CYCLES-1. HALF_CYCLES=1 gives tick every cycle.
- All FSM transitions except UPDATE occur only on tick cycles.
- IDLE: latch=0, clk=0. Counts ticks. On the POLL_TICKS-th tick -> LATCH, poll count cleared.
- LATCH: nes_latch=1 for 2 ticks. On the 2nd tick: shift <= {shift[6:0], ~nes_data} (captures A), bit count=1, -> PULSE.
- PULSE: nes_clk=1 for 1 tick, -> SAMPLE.
- SAMPLE: nes_clk=0 for 1 tick. On that tick: shift in ~nes_data, bit count+1. If bit count was 7 -> UPDATE, else -> PULSE.
- UPDATE: lasts 1 clk cycle regardless of tick.
  - buttons <= shift; buttons_valid=1.
  - new = shift & ~buttons(old).
  - select_pulse=new[5]; start_pulse=new[4].
  - mux_select: new[7] -> 0, else new[6] -> 1, else hold. A wins when A and B are new in the same frame.
  - Then -> IDLE.
- Frame timing: LATCH to UPDATE spans 16 ticks. UPDATE follows on the cycle after the final SAMPLE tick.
- Held buttons re-assert buttons every frame but do not repeat pulses or change mux_select.
- Unplugged pad (data pulled high) reads all zeros, so no events fire.
- nes_latch and nes_clk are registered and glitch-free, and are never high simultaneously.
- Pulse outputs are 0 on all cycles other than UPDATE.

Decomposition:
- Package nes_pkg: state enum {IDLE, LATCH, PULSE, SAMPLE, UPDATE}; NES_BITS=8; BTN_A=7, BTN_B=6, BTN_SELECT=5, BTN_START=4, BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0.
- Sub-module nes_tick_gen (param HALF_CYCLES; ports clk, reset, tick) holds the divider.
- FSM, shift register and edge/event logic live in nes_pad_controller.

Test Plan:
- Reset, then HALF_CYCLES=2, POLL_TICKS=4, nes_data held 1 -> first nes_latch rise 8 cycles after reset release; latch high 4 cycles; 7 nes_clk pulses each 2 cycles high; buttons_valid pulses with buttons=8'h00; mux_select stays 0.
- Pad model drives A pressed only -> buttons=8'h80; mux_select=0; no select/start pulse.
- Next frame B only (8'h40) -> mux_select=1 from the UPDATE cycle. Then A+B new together from none -> mux_select=0 (A priority).
- Select held for 3 frames (8'h20) -> select_pulse exactly once, in the first UPDATE. Release, then press again -> second pulse.
- Start+Right (8'h11) -> buttons=8'h11, start_pulse=1 once, mux_select unchanged. Check bit order against the pad model's serial order A..Right.
- Assert reset during the 4th PULSE -> next cycle nes_clk=0, nes_latch=0, buttons=0. The next full frame after release decodes correctly with no stale shift bits.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES gamepad interface: FSM states,
// frame length and the bit position of each button in the decoded vector.
package nes_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      PULSE  = 3'd2,
      SAMPLE = 3'd3,
      UPDATE = 3'd4
   } nes_state_e;

   localparam int NES_BITS   = 8;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_tick_gen.sv
// Free-running divider producing a one-cycle tick every HALF_CYCLES clocks;
// one tick is one half-period of the pad latch/clock protocol.
module nes_tick_gen #(
   parameter int HALF_CYCLES = 300
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

   logic [CW-1:0] div_q, div_d;

   // With HALF_CYCLES=1 the counter sits at 0 and tick is permanently high.
   assign tick = (div_q == LAST);

   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) div_q <= '0;
      else       div_q <= div_d;
   end

endmodule

// File: rtl/nes_pad_controller.sv
// Polls the NES pad shift register, deserialises the 8 buttons and derives
// the add/subtract select plus Select/Start press events for the datapath.
module nes_pad_controller
   import nes_pkg::*;
#(
   parameter int HALF_CYCLES = 300,
   parameter int POLL_TICKS  = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic       mux_select,
   output logic       select_pulse,
   output logic       start_pulse
);

   localparam int PW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TICKS - 1);

   logic                tick;
   nes_state_e          state_q, state_d;
   logic [PW-1:0]       poll_q, poll_d;
   logic [2:0]          bit_q, bit_d;
   logic [NES_BITS-1:0] shift_q, shift_d;

   logic                latch_q, latch_d;
   logic                nclk_q, nclk_d;
   logic [NES_BITS-1:0] buttons_q, buttons_d;
   logic                valid_q, valid_d;
   logic                mux_q, mux_d;
   logic                sel_q, sel_d;
   logic                start_q, start_d;
   logic [NES_BITS-1:0] new_w;
   logic                upd_w;

   nes_tick_gen #(.HALF_CYCLES(HALF_CYCLES)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // poll_q counts IDLE ticks, then is reused to time the two latch ticks.
   always_comb begin
      state_d = state_q;
      poll_d  = poll_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: if (tick) begin
            if (poll_q == POLL_LAST) begin
               poll_d  = '0;
               state_d = LATCH;
            end else begin
               poll_d = poll_q + 1'b1;
            end
         end
         LATCH: if (tick) begin
            if (poll_q == PW'(1)) begin
               poll_d  = '0;
               shift_d = {shift_q[NES_BITS-2:0], ~nes_data};
               bit_d   = 3'd1;
               state_d = PULSE;
            end else begin
               poll_d = poll_q + 1'b1;
            end
         end
         PULSE: if (tick) state_d = SAMPLE;
         SAMPLE: if (tick) begin
            shift_d = {shift_q[NES_BITS-2:0], ~nes_data};
            bit_d   = bit_q + 1'b1;
            state_d = (bit_q == 3'(NES_BITS - 1)) ? UPDATE : PULSE;
         end
         UPDATE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the pins and the event
   // pulses line up exactly with the state they belong to.
   always_comb begin
      upd_w     = (state_d == UPDATE);
      new_w     = shift_d & ~buttons_q;
      latch_d   = (state_d == LATCH);
      nclk_d    = (state_d == PULSE);
      valid_d   = upd_w;
      buttons_d = upd_w ? shift_d : buttons_q;
      sel_d     = upd_w & new_w[BTN_SELECT];
      start_d   = upd_w & new_w[BTN_START];
      mux_d     = mux_q;
      if (upd_w) begin
         if (new_w[BTN_A])      mux_d = 1'b0;
         else if (new_w[BTN_B]) mux_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         poll_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         latch_q   <= 1'b0;
         nclk_q    <= 1'b0;
         buttons_q <= '0;
         valid_q   <= 1'b0;
         mux_q     <= 1'b0;
         sel_q     <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         poll_q    <= poll_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         latch_q   <= latch_d;
         nclk_q    <= nclk_d;
         buttons_q <= buttons_d;
         valid_q   <= valid_d;
         mux_q     <= mux_d;
         sel_q     <= sel_d;
         start_q   <= start_d;
      end
   end

   assign nes_latch     = latch_q;
   assign nes_clk       = nclk_q;
   assign buttons       = buttons_q;
   assign buttons_valid = valid_q;
   assign mux_select    = mux_q;
   assign select_pulse  = sel_q;
   assign start_pulse   = start_q;

endmodule

// File: tb/tb_nes_pad_controller.sv
// Bench for nes_pad_controller: behavioural 4021-style pad model, frame table
// with hand-computed expectations, and protocol timing / reset sequences.
module tb_nes_pad_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       nes_data;
   logic       nes_latch;
   logic       nes_clk;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic       mux_select;
   logic       select_pulse;
   logic       start_pulse;

   int errors = 0;
   int checks = 0;

   // clock / reset block
   always #5 clk = ~clk;

   nes_pad_controller #(.HALF_CYCLES(2), .POLL_TICKS(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .nes_data      (nes_data),
      .nes_latch     (nes_latch),
      .nes_clk       (nes_clk),
      .buttons       (buttons),
      .buttons_valid (buttons_valid),
      .mux_select    (mux_select),
      .select_pulse  (select_pulse),
      .start_pulse   (start_pulse)
   );

   // Pad model: parallel load on latch, shift on each clock rise; A leaves first.
   logic [7:0] pad_buttons   = 8'h00;
   logic       pad_connected = 1'b0;
   logic [7:0] pad_sr        = 8'h00;

   always @(posedge nes_latch or posedge nes_clk) begin
      if (nes_latch) pad_sr = pad_buttons;
      else           pad_sr = {pad_sr[6:0], 1'b0};
   end

   assign nes_data = pad_connected ? ~pad_sr[7] : 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: {buttons, mux_select, select_pulse, start_pulse}
   logic [10:0] exp_q[$];
   logic        last_mux = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         check("latch_clk_excl", 32'(nes_latch & nes_clk), 32'd0);
         check("pulse_outside_update", 32'((select_pulse | start_pulse) & ~buttons_valid), 32'd0);
         check("mux_hold", 32'((mux_select != last_mux) & ~buttons_valid), 32'd0);
         if (buttons_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_update", 32'd1, 32'd0);
            end else begin
               logic [10:0] e;
               e = exp_q.pop_front();
               check("buttons", 32'(buttons), 32'(e[10:3]));
               check("mux_select", 32'(mux_select), 32'(e[2]));
               check("select_pulse", 32'(select_pulse), 32'(e[1]));
               check("start_pulse", 32'(start_pulse), 32'(e[0]));
            end
         end
      end
      last_mux = mux_select;
   end

   typedef struct {
      logic [7:0] pad;
      logic       plugged;
      logic [7:0] exp_btn;
      logic       exp_mux;
      logic       exp_sel;
      logic       exp_start;
   } vec_t;

   vec_t tbl[14];

   task automatic push_exp(input logic [7:0] b, input logic m, input logic s, input logic st);
      exp_q.push_back({b, m, s, st});
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!buttons_valid && k < 300);
      check(name, 32'(buttons_valid), 32'd1);
   endtask

   initial begin
      int n, w, p, run, minw, maxw, guard;

      tbl[0]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};  // unplugged
      tbl[1]  = '{8'h80, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};  // A
      tbl[2]  = '{8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0};  // B -> subtract
      tbl[3]  = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{8'hC0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0};  // A+B new: A wins
      tbl[5]  = '{8'h20, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0};  // Select press
      tbl[6]  = '{8'h20, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{8'h20, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};  // unplugged
      tbl[9]  = '{8'h20, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0};  // Select again
      tbl[10] = '{8'h11, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};  // Start+Right
      tbl[11] = '{8'h11, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      pad_buttons   = tbl[0].pad;
      pad_connected = tbl[0].plugged;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({nes_latch, nes_clk, buttons, buttons_valid, mux_select, select_pulse, start_pulse}),
            32'd0);
      push_exp(tbl[0].exp_btn, tbl[0].exp_mux, tbl[0].exp_sel, tbl[0].exp_start);

      // First frame: protocol timing.
      reset = 1'b0;
      n = 0;
      while (!nes_latch && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("latch_delay", n, 8);
      w = 0;
      while (nes_latch && w < 100) begin
         w++;
         @(negedge clk);
      end
      check("latch_width", w, 4);
      p = 0; run = 0; minw = 99; maxw = 0; guard = 0;
      while (!buttons_valid && guard < 300) begin
         if (nes_clk) begin
            run++;
         end else if (run > 0) begin
            p++;
            if (run < minw) minw = run;
            if (run > maxw) maxw = run;
            run = 0;
         end
         @(negedge clk);
         guard++;
      end
      check("frame0_valid", 32'(buttons_valid), 32'd1);
      check("clk_pulses", p, 7);
      check("clk_min_width", minw, 2);
      check("clk_max_width", maxw, 2);

      for (int i = 1; i < 14; i++) begin
         pad_buttons   = tbl[i].pad;
         pad_connected = tbl[i].plugged;
         push_exp(tbl[i].exp_btn, tbl[i].exp_mux, tbl[i].exp_sel, tbl[i].exp_start);
         wait_valid($sformatf("frame%0d_valid", i));
      end

      // Reset during the 4th clock pulse of a frame.
      pad_buttons   = 8'hFF;
      pad_connected = 1'b1;
      p = 0; guard = 0; run = 0;
      while (p < 4 && guard < 300) begin
         @(negedge clk);
         guard++;
         if (nes_clk && !run) p++;
         run = nes_clk;
      end
      check("reached_pulse4", p, 4);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_nes_clk", 32'(nes_clk), 32'd0);
      check("midreset_nes_latch", 32'(nes_latch), 32'd0);
      check("midreset_buttons", 32'(buttons), 32'd0);
      check("midreset_mux", 32'(mux_select), 32'd0);
      repeat (2) @(negedge clk);

      pad_buttons = 8'h65;  // B, Select, Down, Right
      push_exp(8'h65, 1'b1, 1'b1, 1'b0);
      reset = 1'b0;
      wait_valid("post_reset_valid");
      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
